// File: rtl/rx_seq_pkg.sv
// rtl/rx_seq_pkg.sv - shared state encoding and sequence constants for the RX packet sequencer
package rx_seq_pkg;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_PRE  = 2'd1,
    RX_DATA = 2'd2
  } rx_state_e;

  localparam logic [31:0] DEF_RESYNC_SEQ = 32'h416F_DC1E;
  localparam logic [31:0] DEF_MAGIC_SEQ  = 32'hD78C_1B74;
  localparam int          DROP_W         = 16;

endpackage

// File: rtl/seq_matcher.sv
// rtl/seq_matcher.sv - four-byte match window with resync/magic compare on the post-shift value
module seq_matcher #(
  parameter logic [31:0] RESYNC_SEQ = 32'h416F_DC1E,
  parameter logic [31:0] MAGIC_SEQ  = 32'hD78C_1B74
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [7:0] i_rx_byte,
  input  logic       i_rx_byte_valid,
  output logic       resync_hit,
  output logic       magic_hit
);

  logic [31:0] win;
  logic [31:0] win_next;
  logic        unused_win_msb;

  assign win_next       = {win[23:0], i_rx_byte};
  assign resync_hit     = i_rx_byte_valid && (win_next == RESYNC_SEQ);
  assign magic_hit      = i_rx_byte_valid && (win_next == MAGIC_SEQ);
  assign unused_win_msb = ^win[31:24];

  // A resync empties the window so its tail cannot seed a later match.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      win <= '0;
    end else if (i_rx_byte_valid) begin
      win <= resync_hit ? '0 : win_next;
    end
  end

endmodule

// File: rtl/rx_packet_sequencer.sv
// rtl/rx_packet_sequencer.sv - UART RX framing FSM, payload forwarding, FIFO write gating and drop count
// Optional payload length limit enabled by defining RX_SEQ_LENGTH_LIMIT_EN.
module rx_packet_sequencer
  import rx_seq_pkg::*;
#(
  parameter int          PAYLOAD_WORDS = 1024,
  parameter logic [31:0] RESYNC_SEQ    = DEF_RESYNC_SEQ,
  parameter logic [31:0] MAGIC_SEQ     = DEF_MAGIC_SEQ
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [7:0]        i_rx_byte,
  input  logic              i_rx_byte_valid,
  input  logic              i_word_valid,
  input  logic              i_fifo_full,
  output logic [7:0]        o_byte,
  output logic              o_byte_valid,
  output logic              o_deser_clear,
  output logic              o_start_packet_sig,
  output logic              o_fifo_wr,
  output logic [DROP_W-1:0] o_drop_count,
  output logic [1:0]        o_state
);

  rx_state_e state_q, state_d;
  logic      resync_hit, magic_hit;
  logic      fwd_d, clr_d, sop_d;
  logic      limit_hit;

  seq_matcher #(
    .RESYNC_SEQ (RESYNC_SEQ),
    .MAGIC_SEQ  (MAGIC_SEQ)
  ) u_matcher (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_rx_byte       (i_rx_byte),
    .i_rx_byte_valid (i_rx_byte_valid),
    .resync_hit      (resync_hit),
    .magic_hit       (magic_hit)
  );

`ifdef RX_SEQ_LENGTH_LIMIT_EN
  localparam int CNT_W = $clog2(PAYLOAD_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_WORDS - 1);

  logic [CNT_W-1:0] word_cnt;

  // Dropped words still count toward the payload length.
  assign limit_hit = (state_q == RX_DATA) && i_word_valid && (word_cnt == LAST_CNT);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      word_cnt <= '0;
    end else if (state_q == RX_PRE && magic_hit) begin
      word_cnt <= '0;
    end else if (state_q == RX_DATA && i_word_valid) begin
      word_cnt <= limit_hit ? '0 : word_cnt + 1'b1;
    end
  end
`else
  logic unused_payload_words;

  assign limit_hit            = 1'b0;
  assign unused_payload_words = (PAYLOAD_WORDS == 0);
`endif

  always_comb begin
    state_d = state_q;
    fwd_d   = 1'b0;
    clr_d   = 1'b0;
    sop_d   = 1'b0;
    if (resync_hit) begin
      state_d = RX_IDLE;
      clr_d   = 1'b1;
    end else begin
      case (state_q)
        RX_IDLE: if (i_rx_byte_valid) state_d = RX_PRE;
        RX_PRE: begin
          if (magic_hit) begin
            state_d = RX_DATA;
            clr_d   = 1'b1;
            sop_d   = 1'b1;
          end
        end
        RX_DATA: begin
          if (limit_hit) state_d = RX_IDLE;
          else           fwd_d   = i_rx_byte_valid;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q            <= RX_IDLE;
      o_byte             <= '0;
      o_byte_valid       <= 1'b0;
      o_deser_clear      <= 1'b0;
      o_start_packet_sig <= 1'b0;
    end else begin
      state_q            <= state_d;
      o_byte_valid       <= fwd_d;
      o_deser_clear      <= clr_d;
      o_start_packet_sig <= sop_d;
      if (fwd_d) o_byte <= i_rx_byte;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_drop_count <= '0;
    end else if (i_word_valid && i_fifo_full && (o_drop_count != '1)) begin
      o_drop_count <= o_drop_count + 1'b1;
    end
  end

  assign o_fifo_wr = i_word_valid & ~i_fifo_full;
  assign o_state   = state_q;

endmodule

// File: doc/rx_packet_sequencer.md
# rx_packet_sequencer

Packet-level controller for the UART receive path. Sits between the UART byte receiver and the byte-to-word deserialiser and RX FIFO. Tracks the IDLE/PRE/DATA framing, forwards only payload bytes to the deserialiser and pulses start-of-packet. Gates FIFO writes against the full flag and counts dropped words for the DataManager.

## Interface
- `PAYLOAD_WORDS`, default 1024: payload length in 32-bit words. Used only with `RX_SEQ_LENGTH_LIMIT_EN`.
- `RESYNC_SEQ`, default 32'h416F_DC1E: resync sequence. First received byte is the MSB.
- `MAGIC_SEQ`, default 32'hD78C_1B74: start-of-payload sequence. First received byte is the MSB.
- `i_clock`  in  1  system clock (50 MHz).
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_rx_byte`  in  8  byte from the UART receiver.
- `i_rx_byte_valid`  in  1  one-cycle strobe: `i_rx_byte` is valid.
- `i_word_valid`  in  1  one-cycle strobe from the deserialiser: a full word is ready.
- `i_fifo_full`  in  1  RX FIFO full flag.
- `o_byte`  out  8  payload byte to the deserialiser.
- `o_byte_valid`  out  1  one-cycle strobe for `o_byte`.
- `o_deser_clear`  out  1  one-cycle pulse that realigns the deserialiser to byte 0.
- `o_start_packet_sig`  out  1  one-cycle pulse on entry to DATA.
- `o_fifo_wr`  out  1  FIFO write request.
- `o_drop_count`  out  16  saturating count of words dropped because the FIFO was full.
- `o_state`  out  2  current state: 0=IDLE, 1=PRE, 2=DATA.

## Operation
- **Match window:** a 32-bit shift register holds the last four received bytes. Each `i_rx_byte_valid` shifts `i_rx_byte` into the LSB.
- **Match evaluation:** matches are evaluated on the post-shift value, i.e. `{win[23:0], i_rx_byte}`.
- **IDLE:** wait for any byte. Every received byte moves the FSM to PRE. No bytes are forwarded.
- **PRE:** the window equals `MAGIC_SEQ` → DATA, and assert `o_start_packet_sig` and `o_deser_clear`. Otherwise stay in PRE. Magic bytes are never forwarded.
- **DATA:** each received byte is forwarded through `o_byte`/`o_byte_valid`.
- **Resync:** the window equals `RESYNC_SEQ` in any state → IDLE.
  - The window is cleared to 0.
  - `o_deser_clear` pulses.
  - The completing byte is not forwarded.
  - In DATA, up to three resync bytes may already have been forwarded; `o_deser_clear` discards the partial word.
- **Priority:** resync beats magic, which beats the payload-end check.
- **FIFO write:** `o_fifo_wr = i_word_valid & ~i_fifo_full` (combinational).
- **Dropped words:** `i_word_valid & i_fifo_full` increments `o_drop_count`, saturating at 16'hFFFF. `o_drop_count` is cleared only by reset.

## Timing
- **Reset values:** `o_state`=IDLE, `o_byte`=0, `o_byte_valid`=0, `o_deser_clear`=0, `o_start_packet_sig`=0, `o_drop_count`=0. The window register resets to 0; the word counter resets to 0.
- **Byte forwarding:** `o_byte`/`o_byte_valid` are registered, one cycle after `i_rx_byte_valid`.
- **Magic:** `o_start_packet_sig`, `o_deser_clear` and the state change are registered, one cycle after the final magic byte's strobe.
- **Resync:** `o_deser_clear` and the move to IDLE are registered, one cycle after the final resync byte's strobe.
- **Back-to-back bytes:** consecutive `i_rx_byte_valid` cycles must be handled without loss. UART rate makes this rare, but it is required.
- **Reset mid-packet:** all state is abandoned immediately. No further bytes are forwarded until a new magic sequence arrives.
- **`o_fifo_wr`:** zero latency from `i_word_valid`, and never asserted while `i_fifo_full` is 1.

## Configuration
- **`RX_SEQ_LENGTH_LIMIT_EN` defined:**
  - A word counter of width `$clog2(PAYLOAD_WORDS+1)` counts `i_word_valid` pulses in DATA, including dropped words.
  - When the count reaches `PAYLOAD_WORDS`, go to IDLE in the following cycle and reset the counter.
  - The counter also resets on magic entry.
  - Bytes arriving after that are not forwarded.
- **Not defined:** DATA persists until a resync; there is no counter.

## Structure
- Shared package `rx_seq_pkg`:
  - state encoding (`RX_IDLE`, `RX_PRE`, `RX_DATA`);
  - default `RESYNC_SEQ` and `MAGIC_SEQ` constants;
  - drop counter width.
- One sub-module, `seq_matcher`: the shift window plus the two compare outputs (`resync_hit`, `magic_hit`).
- The FSM, forwarding register, FIFO gating and counters stay in the top level.

## Test plan
- **Magic entry:** reset, then bytes D7,8C,1B,74 → `o_start_packet_sig` and `o_deser_clear` pulse once, `o_state`=2, and no `o_byte_valid`. Then bytes 01,02,03,04 → four `o_byte_valid` pulses carrying 01..04.
- **Mid-payload resync:** in DATA, bytes 41,6F,DC,1E → `o_state`=0 one cycle after the 1E strobe, and `o_deser_clear` pulses. The following byte AA is not forwarded.
- **Non-matching preamble:** in PRE, bytes D7,8C,1B,75, then D7,8C,1B,74 → stays PRE after the first group and enters DATA only after the second.
- **FIFO full:** `i_fifo_full`=1 with three `i_word_valid` pulses → `o_fifo_wr` stays 0 and `o_drop_count`=3. Deassert full, then one pulse → `o_fifo_wr`=1 and the count stays 3.
- **Length limit** (`RX_SEQ_LENGTH_LIMIT_EN`, `PAYLOAD_WORDS`=2): magic, then two `i_word_valid` pulses → `o_state`=0 the cycle after the second pulse. Further bytes are not forwarded.
- **Async reset:** assert `i_reset` mid-DATA between clock edges → `o_state`=0 and all outputs at their reset values immediately.
